cache_fill_ctrl: RTL

Controller between the cache tag/data arrays and the single-port, byte-addressed, 16-bit main memory, whose reads are combinational and whose writes occur on the clock edge. It performs 8-word (16-byte) block fills on a cache miss and forwards write-through stores to memory. It owns the memory port exclusively and never overlaps a fill with a store.

---
 rtl/cache_fill_ctrl_if.sv | 35 +++
 rtl/cache_fill_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl_if.sv
// Bundle of cache-side request/response and memory-port signals for cache_fill_ctrl.
// master = the fill controller, slave = the cache arrays and main memory.
interface cache_fill_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 16
);
    logic                  miss_detected;
    logic [ADDR_WIDTH-1:0] miss_addr;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [15:0]           wr_data;
    logic                  wr_ack;
    logic                  fsm_busy;
    logic                  fill_done;
    logic                  write_data_array;
    logic                  write_tag_array;
    logic [ADDR_WIDTH-1:0] fill_word_addr;
    logic [15:0]           fill_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_en;
    logic                  mem_wr;
    logic [15:0]           mem_wdata;
    logic [15:0]           mem_rdata;

    modport master (
        input  miss_detected, miss_addr, wr_req, wr_addr, wr_data, mem_rdata,
        output wr_ack, fsm_busy, fill_done, write_data_array, write_tag_array,
               fill_word_addr, fill_data, mem_addr, mem_en, mem_wr, mem_wdata
    );

    modport slave (
        output miss_detected, miss_addr, wr_req, wr_addr, wr_data, mem_rdata,
        input  wr_ack, fsm_busy, fill_done, write_data_array, write_tag_array,
               fill_word_addr, fill_data, mem_addr, mem_en, mem_wr, mem_wdata
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Block-fill / write-through controller owning the single memory port.
// Define FILL_CRITICAL_FIRST_EN to start fills at the missing word and wrap.
module cache_fill_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned BLOCK_WORDS = 8
) (
    input logic             clk,
    input logic             rst,
    cache_fill_ctrl_if.master bus
);
    localparam int unsigned CntW  = $clog2(BLOCK_WORDS);
    localparam int unsigned OffW  = CntW + 1;
    localparam int unsigned BaseW = ADDR_WIDTH - OffW;
    localparam logic [CntW-1:0] LastIdx = CntW'(BLOCK_WORDS - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFill  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [CntW-1:0]       done_q, done_d;
    logic [BaseW-1:0]      base_q, base_d;
    logic [ADDR_WIDTH-1:1] wr_addr_q, wr_addr_d;
    logic [15:0]           wr_data_q, wr_data_d;
    logic [CntW-1:0]       start_cnt;
    logic                  last_word;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic                  unused_bits;

`ifdef FILL_CRITICAL_FIRST_EN
    assign start_cnt   = bus.miss_addr[OffW-1:1];
    assign unused_bits = ^{bus.wr_addr[0], bus.miss_addr[0]};
`else
    assign start_cnt   = '0;
    assign unused_bits = ^{bus.wr_addr[0], bus.miss_addr[OffW-1:0]};
`endif

    // Completion follows the done-count, not cnt, so wrapped fills still take 8 words.
    assign last_word = (state_q == StFill) && (done_q == LastIdx);
    assign fill_addr = {base_q, cnt_q, 1'b0};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        base_d    = base_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            StIdle: begin
                if (bus.wr_req) begin
                    wr_addr_d = bus.wr_addr[ADDR_WIDTH-1:1];
                    wr_data_d = bus.wr_data;
                    state_d   = StWrite;
                end else if (bus.miss_detected) begin
                    base_d  = bus.miss_addr[ADDR_WIDTH-1:OffW];
                    cnt_d   = start_cnt;
                    done_d  = '0;
                    state_d = StFill;
                end
            end
            StFill: begin
                cnt_d  = cnt_q + CntW'(1);
                done_d = done_q + CntW'(1);
                if (last_word) state_d = StIdle;
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            done_q    <= '0;
            base_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            base_q    <= base_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        bus.wr_ack           = 1'b0;
        bus.fsm_busy         = 1'b0;
        bus.fill_done        = 1'b0;
        bus.write_data_array = 1'b0;
        bus.write_tag_array  = 1'b0;
        bus.fill_word_addr   = '0;
        bus.fill_data        = '0;
        bus.mem_addr         = '0;
        bus.mem_en           = 1'b0;
        bus.mem_wr           = 1'b0;
        bus.mem_wdata        = '0;
        case (state_q)
            StFill: begin
                bus.fsm_busy         = 1'b1;
                bus.mem_en           = 1'b1;
                bus.mem_addr         = fill_addr;
                bus.write_data_array = 1'b1;
                bus.fill_word_addr   = fill_addr;
                bus.fill_data        = bus.mem_rdata;
                bus.write_tag_array  = last_word;
                bus.fill_done        = last_word;
            end
            StWrite: begin
                bus.fsm_busy  = 1'b1;
                bus.mem_en    = 1'b1;
                bus.mem_wr    = 1'b1;
                bus.mem_addr  = {wr_addr_q, 1'b0};
                bus.mem_wdata = wr_data_q;
                bus.wr_ack    = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
